header_sched: RTL and testbench

//  Round-robin scheduler and flow controller for the header (min/max) stage.
//  - Shares one header stage between NUM_REQ 32-pixel block sources.
//  - Issues at most one block per cycle into the stall-free header stage.
//  - Tags each result with its source and derives per-channel residual widths
//    and the real compressable flag.
//  - Buffers results in an output FIFO so back-pressure never drops a result.

---
 rtl/header_sched.sv | 208 ++++++++++++++++++++
 tb/tb_header_sched.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/header_sched.sv
// -----------------------------------------------------------------------------
// header_sched_pkg / header_sched
//
// Shares one stall-free header (min/max) stage between NUM_REQ block sources.
// A round-robin arbiter issues at most one 32-pixel block per cycle. The header
// result comes back one cycle after issue. It is tagged with its source and
// with per-channel residual widths, and the compressable flag is recomputed.
// The tagged result is then buffered in a result FIFO. Credits count buffered
// plus in-flight results, so back-pressure can never drop a result.
//
// Ports
//   clk          clock
//   rst          asynchronous active-low reset
//   sched_en     1 = new issues allowed, 0 = drain only
//   req_valid    per-source block available
//   req_pixels   per-source block
//   req_ready    one-hot grant; the granted block is consumed this cycle
//   hdr_rst      active-high reset to the header stage
//   hdr_pixels   granted block driven to the header stage
//   hdr_hr       header stage result, valid one cycle after issue
//   out_valid    FIFO head valid
//   out_ready    consumer accepts head
//   out_hr       head result with compressable recomputed
//   out_src      source index of head
//   out_bits     residual widths packed as {r, g, b, a}; out_bits[3] is r
//   busy         any block in flight or buffered
// -----------------------------------------------------------------------------
package header_sched_pkg;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] a;
  } pixel_t;

  typedef pixel_t [31:0] pixels_t;

  typedef struct packed {
    pixel_t min_px;
    pixel_t max_px;
    logic   compressable;
  } header_residual_reg;
endpackage

module header_sched
  import header_sched_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int MAX_RES_BITS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sched_en,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  pixels_t                    req_pixels [NUM_REQ],
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       hdr_rst,
  output pixels_t                    hdr_pixels,
  input  header_residual_reg         hdr_hr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output header_residual_reg         out_hr,
  output logic [$clog2(NUM_REQ)-1:0] out_src,
  output logic [3:0][3:0]            out_bits,
  output logic                       busy
);

  localparam int SW = $clog2(NUM_REQ);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    header_residual_reg hr;
    logic [SW-1:0]      src;
    logic [3:0][3:0]    bits;
  } entry_t;

  logic               hdr_rst_q;
  logic [SW-1:0]      rr_q, rr_d;
  logic               issue_v_q;
  logic [SW-1:0]      src_q;
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q;
  entry_t             mem_q [FIFO_DEPTH];

  logic [CW:0]        occ;
  logic               issue_ok;
  logic               gnt_found;
  logic               gnt_v;
  logic [SW-1:0]      gnt_idx;
  logic               push, pop;
  entry_t             push_entry;

  // Width of a residual range: 0 for an empty range, else MSB position + 1.
  function automatic logic [3:0] res_bits(input logic [7:0] mx, input logic [7:0] mn);
    logic [7:0] range;
    range    = mx - mn;
    res_bits = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (range[i]) res_bits = 4'(i + 1);
    end
  endfunction

  // The in-flight result already owns a FIFO slot, and a same-cycle pop is
  // not counted, so the FIFO can never overflow.
  assign occ      = {1'b0, count_q} + {{CW{1'b0}}, issue_v_q};
  assign issue_ok = sched_en && !hdr_rst_q && (occ < (CW+1)'(FIFO_DEPTH));

  // Round-robin search: first valid source at or after rr_q, wrapping.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // a variable unassigned and infer a latch.
  always_comb begin : grant_comb
    int j;
    j         = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(rr_q) + k) % NUM_REQ;
      if (!gnt_found && req_valid[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = SW'(j);
      end
    end
  end

  assign gnt_v      = issue_ok && gnt_found;
  assign req_ready  = gnt_v ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign hdr_pixels = gnt_v ? req_pixels[gnt_idx] : req_pixels[0];

  always_comb begin
    rr_d = rr_q;
    if (gnt_v) rr_d = (gnt_idx == SW'(NUM_REQ - 1)) ? '0 : gnt_idx + SW'(1);
  end

  // Header stage reset: set asynchronously, released on the first edge.
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the values from before the edge, whatever the block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hdr_rst_q <= 1'b1;
    else      hdr_rst_q <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q      <= '0;
      issue_v_q <= 1'b0;
      src_q     <= '0;
    end else begin
      rr_q      <= rr_d;
      issue_v_q <= gnt_v;
      src_q     <= gnt_idx;
    end
  end

  // Tag the returning header result, which is aligned with issue_v_q/src_q.
  always_comb begin
    logic cmp;
    push_entry      = '0;
    push_entry.hr   = hdr_hr;
    push_entry.src  = src_q;
    push_entry.bits = {res_bits(hdr_hr.max_px.r, hdr_hr.min_px.r),
                       res_bits(hdr_hr.max_px.g, hdr_hr.min_px.g),
                       res_bits(hdr_hr.max_px.b, hdr_hr.min_px.b),
                       res_bits(hdr_hr.max_px.a, hdr_hr.min_px.a)};
    cmp = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (push_entry.bits[c] > 4'(MAX_RES_BITS)) cmp = 1'b0;
    end
    push_entry.hr.compressable = cmp;
  end

  assign push      = issue_v_q;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; count_q alone decides which entries
  // are meaningful, so clearing the data would buy nothing.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign out_hr   = mem_q[rd_ptr_q].hr;
  assign out_src  = mem_q[rd_ptr_q].src;
  assign out_bits = mem_q[rd_ptr_q].bits;
  assign busy     = (occ != '0);
  assign hdr_rst  = hdr_rst_q;

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
    !(push && (count_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_header_sched.sv
// -----------------------------------------------------------------------------
// tb_header_sched
//
// Bench for header_sched. A behavioural header stage drives hdr_hr, with a
// random incoming compressable bit so that the recomputed flag is exercised.
// The reference model is a scoreboard queue. It predicts grants from the
// round-robin rule and the occupancy budget, and it predicts results from
// min/max and $clog2 arithmetic over the granted block.
// -----------------------------------------------------------------------------
module tb_header_sched;
  import header_sched_pkg::*;

  localparam int NR  = 2;
  localparam int FD  = 4;
  localparam int MRB = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               sched_en;
  logic [NR-1:0]      req_valid;
  pixels_t            req_pixels [NR];
  logic [NR-1:0]      req_ready;
  logic               hdr_rst;
  pixels_t            hdr_pixels;
  header_residual_reg hdr_hr;
  logic               out_valid;
  logic               out_ready;
  header_residual_reg out_hr;
  logic [0:0]         out_src;
  logic [3:0][3:0]    out_bits;
  logic               busy;

  header_sched #(.NUM_REQ(NR), .FIFO_DEPTH(FD), .MAX_RES_BITS(MRB)) dut (
    .clk(clk), .rst(rst), .sched_en(sched_en), .req_valid(req_valid),
    .req_pixels(req_pixels), .req_ready(req_ready), .hdr_rst(hdr_rst),
    .hdr_pixels(hdr_pixels), .hdr_hr(hdr_hr), .out_valid(out_valid),
    .out_ready(out_ready), .out_hr(out_hr), .out_src(out_src),
    .out_bits(out_bits), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 src;
    header_residual_reg hr;
    logic [3:0][3:0]    bits;
  } exp_t;

  typedef struct {
    pixel_t          lo;
    pixel_t          hi;
    logic [3:0][3:0] bits;
    logic            cmp;
  } vec_t;

  exp_t sb [$];
  exp_t pend;
  bit   pend_v;
  int   rr;
  bit   hrst_m;
  int   gnt_log [$];
  int   n_vec;
  int   n_bad;

  function automatic header_residual_reg minmax(input pixels_t p, input logic c);
    logic [3:0][7:0] mn, mx, v;
    mn = '1;
    mx = '0;
    for (int i = 0; i < 32; i++) begin
      v = p[i];
      for (int ch = 0; ch < 4; ch++) begin
        if (v[ch] < mn[ch]) mn[ch] = v[ch];
        if (v[ch] > mx[ch]) mx[ch] = v[ch];
      end
    end
    minmax.min_px       = mn;
    minmax.max_px       = mx;
    minmax.compressable = c;
  endfunction

  // Stall-free header stage: one cycle of latency, cleared by hdr_rst.
  always @(posedge clk or posedge hdr_rst) begin
    if (hdr_rst) hdr_hr <= '0;
    else         hdr_hr <= minmax(hdr_pixels, 1'($urandom_range(0, 1)));
  end

  function automatic exp_t predict(input int src, input pixels_t p);
    exp_t            e;
    logic [3:0][7:0] mn, mx;
    int              rng;
    bit              cmp;
    e.hr = minmax(p, 1'b0);
    mn   = e.hr.min_px;
    mx   = e.hr.max_px;
    cmp  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      rng = int'(mx[c]) - int'(mn[c]);
      e.bits[c] = (rng == 0) ? 4'd0 : 4'($clog2(rng + 1));
      if (int'(e.bits[c]) > MRB) cmp = 1'b0;
    end
    e.hr.compressable = cmp;
    e.src = src;
    return e;
  endfunction

  function automatic pixels_t ramp(input pixel_t lo, input pixel_t hi);
    logic [3:0][7:0] l, h, v;
    pixels_t         p;
    l = lo;
    h = hi;
    for (int i = 0; i < 32; i++) begin
      for (int ch = 0; ch < 4; ch++)
        v[ch] = 8'(int'(l[ch]) + ((int'(h[ch]) - int'(l[ch])) * i) / 31);
      p[i] = v;
    end
    return p;
  endfunction

  function automatic pixels_t rand_block();
    logic [3:0][7:0] v;
    int              base [4];
    int              span [4];
    pixels_t         p;
    for (int ch = 0; ch < 4; ch++) begin
      span[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 20));
      base[ch] = int'($urandom_range(0, 255 - span[ch]));
    end
    for (int i = 0; i < 32; i++) begin
      for (int ch = 0; ch < 4; ch++)
        v[ch] = 8'(base[ch] + int'($urandom_range(0, span[ch])));
      p[i] = v;
    end
    return p;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, compare against the
  // model, then advance the model across the rising edge.
  task automatic step(input logic [1:0] rv, input logic en, input logic ordy);
    int         g;
    int         occ;
    bit         pop_e;
    logic [1:0] exp_rdy;
    exp_t       nxt;
    req_valid = rv;
    sched_en  = en;
    out_ready = ordy;
    #1;
    occ = sb.size() + int'(pend_v);
    g   = -1;
    if (en && !hrst_m && occ < FD)
      for (int k = 0; k < NR; k++)
        if (g < 0 && rv[(rr + k) % NR]) g = (rr + k) % NR;
    exp_rdy = (g < 0) ? 2'b00 : 2'(1 << g);
    check("req_ready", req_ready, exp_rdy);
    check("hdr_rst", hdr_rst, hrst_m);
    check("busy", busy, occ != 0);
    check("out_valid", out_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      check("out_src", out_src, sb[0].src);
      check("out_bits", out_bits, sb[0].bits);
      check("out_hr", out_hr, sb[0].hr);
    end
    pop_e = (sb.size() != 0) && ordy;
    nxt   = pend;
    if (g >= 0) begin
      nxt = predict(g, req_pixels[g]);
      gnt_log.push_back(g);
    end
    @(posedge clk);
    if (pop_e) void'(sb.pop_front());
    if (pend_v) sb.push_back(pend);
    pend_v = (g >= 0);
    pend   = nxt;
    if (g >= 0) rr = (g + 1) % NR;
    hrst_m = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [6];
    int   cnt;

    tbl[0] = '{lo: 32'h0A000000, hi: 32'h29000000, bits: 16'h5000, cmp: 1'b0};
    tbl[1] = '{lo: 32'h80808080, hi: 32'h80808080, bits: 16'h0000, cmp: 1'b1};
    tbl[2] = '{lo: 32'h03000000, hi: 32'h12000000, bits: 16'h4000, cmp: 1'b1};
    tbl[3] = '{lo: 32'h00000000, hi: 32'h10080100, bits: 16'h5410, cmp: 1'b0};
    tbl[4] = '{lo: 32'h00101010, hi: 32'hFF1F1011, bits: 16'h8401, cmp: 1'b0};
    tbl[5] = '{lo: 32'h20304050, hi: 32'h2F3F4F5F, bits: 16'h4444, cmp: 1'b1};

    n_vec = 0; n_bad = 0; rr = 0; pend_v = 0; hrst_m = 1;
    rst = 1'b0; sched_en = 1'b0; req_valid = '0; out_ready = 1'b0;
    req_pixels[0] = '0; req_pixels[1] = '0;

    // Reset state, with requests pending.
    @(negedge clk);
    req_valid = 2'b11; sched_en = 1'b1; out_ready = 1'b1;
    #1;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_hdr_rst", hdr_rst, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step(2'b11, 1'b1, 1'b1);          // hdr_rst still high: no issue yet

    // Table-driven residual-width vectors through src0.
    for (int i = 0; i < 6; i++) begin
      req_pixels[0] = ramp(tbl[i].lo, tbl[i].hi);
      req_pixels[1] = rand_block();
      step(2'b01, 1'b1, 1'b1);        // issue cycle
      step(2'b00, 1'b1, 1'b1);        // result in flight
      #1;
      check("tbl_latency_valid", out_valid, 1'b1);
      check("tbl_src", out_src, 1'b0);
      check("tbl_bits", out_bits, tbl[i].bits);
      check("tbl_cmp", out_hr.compressable, tbl[i].cmp);
      step(2'b00, 1'b1, 1'b1);
      step(2'b00, 1'b1, 1'b1);
    end

    // Back-pressure: exactly FD issues, then resume one per pop.
    req_pixels[0] = rand_block();
    req_pixels[1] = rand_block();
    cnt = gnt_log.size();
    repeat (8) step(2'b11, 1'b1, 1'b0);
    check("bp_issue_count", gnt_log.size() - cnt, FD);
    repeat (10) begin
      req_pixels[0] = rand_block();
      req_pixels[1] = rand_block();
      step(2'b11, 1'b1, 1'b1);
    end
    repeat (6) step(2'b00, 1'b1, 1'b1);

    // sched_en dropped right after an issue.
    req_pixels[0] = rand_block();
    step(2'b01, 1'b1, 1'b1);
    cnt = gnt_log.size();
    repeat (4) step(2'b01, 1'b0, 1'b1);
    check("drain_no_issue", gnt_log.size() - cnt, 0);
    #1;
    check("drain_busy_low", busy, 1'b0);

    // Randomized traffic.
    repeat (400) begin
      req_pixels[0] = rand_block();
      req_pixels[1] = rand_block();
      step(2'($urandom_range(0, 3)), 1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 3) != 0));
    end
    repeat (8) step(2'b00, 1'b1, 1'b1);

    // Reset with three results buffered.
    repeat (3) begin
      req_pixels[0] = rand_block();
      step(2'b01, 1'b1, 1'b0);
    end
    repeat (2) step(2'b00, 1'b1, 1'b0);
    #1;
    check("pre_rst_valid", out_valid, 1'b1);
    req_valid = 2'b11; sched_en = 1'b1; out_ready = 1'b1;
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_hdr_rst", hdr_rst, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_req_ready", req_ready, 2'b00);
    sb.delete(); pend_v = 0; rr = 0; hrst_m = 1;
    @(negedge clk);
    rst = 1'b1;
    step(2'b11, 1'b1, 1'b1);
    cnt = gnt_log.size();
    repeat (4) begin
      req_pixels[0] = rand_block();
      req_pixels[1] = rand_block();
      step(2'b11, 1'b1, 1'b1);
    end
    if (gnt_log.size() - cnt == 4) begin
      check("alt_grant0", gnt_log[cnt],     0);
      check("alt_grant1", gnt_log[cnt + 1], 1);
      check("alt_grant2", gnt_log[cnt + 2], 0);
      check("alt_grant3", gnt_log[cnt + 3], 1);
    end else begin
      check("alt_grant_count", gnt_log.size() - cnt, 4);
    end
    repeat (6) step(2'b00, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
